// File: rtl/pattern_shift_register.sv
// rtl/pattern_shift_register.sv - circular shift register serialising a trigger bit pattern
module pattern_shift_register #(
    parameter int               WIDTH         = 10,
    parameter int               CNT_W         = 16,
    parameter bit               INVERT_OUT    = 1'b1,
    parameter bit               IDLE_LEVEL    = 1'b1,
    parameter logic [WIDTH-1:0] RESET_PATTERN = '0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       load,
    input  logic [WIDTH-1:0]           data_in,
    input  logic                       dir,
    input  logic [CNT_W-1:0]           passes_in,
    input  logic                       enable,
    input  logic                       stop,
    output logic                       data_out,
    output logic                       busy,
    output logic                       done,
    output logic [$clog2(WIDTH)-1:0]   bit_idx
);

    localparam int                 IDX_W    = $clog2(WIDTH);
    localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(WIDTH - 1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t             state;
    logic [WIDTH-1:0]   shreg;
    logic               dir_q;
    logic [CNT_W-1:0]   passes_q;
    logic [CNT_W-1:0]   pass_cnt;
    logic [CNT_W-1:0]   pass_next;
    logic [WIDTH-1:0]   rotated;
    logic               last_bit;

    assign rotated   = dir_q ? {shreg[0], shreg[WIDTH-1:1]}
                             : {shreg[WIDTH-2:0], shreg[WIDTH-1]};
    assign last_bit  = (bit_idx == LAST_IDX);
    assign pass_next = pass_cnt + CNT_W'(1);

    // Outputs decode registered state only, so async reset is visible immediately.
    assign busy     = (state == RUN);
    assign data_out = (state == RUN) ? (shreg[0] ^ INVERT_OUT) : IDLE_LEVEL;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            shreg    <= RESET_PATTERN;
            dir_q    <= 1'b0;
            passes_q <= '0;
            pass_cnt <= '0;
            bit_idx  <= '0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            if (load) begin
                shreg    <= data_in;
                dir_q    <= dir;
                passes_q <= passes_in;
                pass_cnt <= '0;
                bit_idx  <= '0;
                state    <= RUN;
            end else if (state == RUN) begin
                if (stop) begin
                    state <= IDLE;
                end else if (enable) begin
                    shreg <= rotated;
                    if (last_bit) begin
                        bit_idx  <= '0;
                        pass_cnt <= pass_next;
                        // passes_q == 0 means continuous: pass_cnt just wraps.
                        if ((passes_q != '0) && (pass_next == passes_q)) begin
                            state <= IDLE;
                            done  <= 1'b1;
                        end
                    end else begin
                        bit_idx <= bit_idx + IDX_W'(1);
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_pattern_shift_register.sv
// tb/tb_pattern_shift_register.sv - randomized self-checking bench for pattern_shift_register
module tb_pattern_shift_register;

    localparam int W = 10;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        load;
    logic [9:0]  data_in;
    logic        dir;
    logic [15:0] passes_in;
    logic        enable;
    logic        stop;
    logic        data_out;
    logic        busy;
    logic        done;
    logic [3:0]  bit_idx;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model: tracks the total number of shifts since load and
    // derives the emitted bit from it with modular arithmetic.
    bit         m_run;
    logic [9:0] m_pat;
    bit         m_dir;
    int         m_passes;
    int         m_shifts;
    bit         m_done;
    logic       exp_out;
    logic       exp_busy;
    logic       exp_done;
    logic [3:0] exp_idx;

    pattern_shift_register dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load),
        .data_in   (data_in),
        .dir       (dir),
        .passes_in (passes_in),
        .enable    (enable),
        .stop      (stop),
        .data_out  (data_out),
        .busy      (busy),
        .done      (done),
        .bit_idx   (bit_idx)
    );

    always #5 clk = ~clk;

    task automatic model_expect();
        int pos;
        int sel;
        pos      = m_shifts % W;
        sel      = m_dir ? pos : (W - pos) % W;
        exp_out  = m_run ? ~m_pat[sel] : 1'b1;
        exp_busy = m_run;
        exp_done = m_done;
        exp_idx  = 4'(pos);
    endtask

    task automatic model_reset();
        m_run    = 0;
        m_shifts = 0;
        m_done   = 0;
        model_expect();
    endtask

    task automatic model_step();
        if (!rst_n) begin
            model_reset();
            return;
        end
        m_done = 0;
        if (load) begin
            m_run    = 1;
            m_pat    = data_in;
            m_dir    = dir;
            m_passes = int'(passes_in);
            m_shifts = 0;
        end else if (m_run && stop) begin
            m_run = 0;
        end else if (m_run && enable) begin
            m_shifts++;
            if (m_passes != 0 && m_shifts == m_passes * W) begin
                m_run  = 0;
                m_done = 1;
            end
        end
        model_expect();
    endtask

    // Advance one clock: inputs are applied at the falling edge, outputs sampled there too.
    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic start(input logic [9:0] pat, input logic d, input logic [15:0] np);
        data_in   = pat;
        dir       = d;
        passes_in = np;
        load      = 1'b1;
        cycle();
        load      = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; load = 0; stop = 0; enable = 0;
        data_in = '0; dir = 0; passes_in = '0;
        model_reset();
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({data_out, busy, done, bit_idx} !== 7'b1000000) begin
            n_fail++;
            $display("FAIL reset_state: got %b exp %b", {data_out, busy, done, bit_idx}, 7'b1000000);
        end
        rst_n = 1'b1;
        enable = 1'b1;
        start(10'b0110100101, 1'b1, 16'd0);
        repeat (3) cycle();
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        n_cmp++;
        if ({data_out, busy, done, bit_idx} !== 7'b1000000) begin
            n_fail++;
            $display("FAIL async_reset: got %b exp %b", {data_out, busy, done, bit_idx}, 7'b1000000);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_single_pass();
        logic [9:0] seq;
        seq    = 10'b1111111010;
        enable = 1'b1;
        start(10'b0000000101, 1'b1, 16'd1);
        for (int i = 0; i < 10; i++) begin
            n_cmp++;
            if (data_out !== seq[i] || {busy, done, bit_idx} !== {exp_busy, exp_done, exp_idx}) begin
                n_fail++;
                $display("FAIL single_pass bit %0d: got out=%b busy=%b done=%b idx=%0d exp out=%b busy=%b done=%b idx=%0d",
                         i, data_out, busy, done, bit_idx, seq[i], exp_busy, exp_done, exp_idx);
            end
            cycle();
        end
        n_cmp++;
        if ({data_out, busy, done, bit_idx} !== 7'b1010000) begin
            n_fail++;
            $display("FAIL single_pass_done: got %b exp %b", {data_out, busy, done, bit_idx}, 7'b1010000);
        end
        cycle();
        n_cmp++;
        if (done !== 1'b0) begin
            n_fail++;
            $display("FAIL done_one_cycle: got %b exp 0", done);
        end
    endtask

    task automatic test_continuous();
        logic [9:0] seq;
        seq    = 10'b0111111100;
        enable = 1'b1;
        start(10'b1000000011, 1'b0, 16'd0);
        for (int i = 0; i < 35; i++) begin
            n_cmp++;
            if (data_out !== seq[i % 10] || data_out !== exp_out || busy !== 1'b1 || done !== 1'b0
                || bit_idx !== exp_idx) begin
                n_fail++;
                $display("FAIL continuous c%0d: got out=%b busy=%b done=%b idx=%0d exp out=%b busy=1 done=0 idx=%0d",
                         i, data_out, busy, done, bit_idx, seq[i % 10], exp_idx);
            end
            cycle();
        end
        stop = 1'b1;
        cycle();
        stop = 1'b0;
    endtask

    task automatic test_enable_toggle();
        int got;
        got = 0;
        start(10'b0000000101, 1'b1, 16'd1);
        for (int c = 1; c <= 40; c++) begin
            enable = (c % 2 == 0);
            cycle();
            n_cmp++;
            if ({data_out, busy, done, bit_idx} !== {exp_out, exp_busy, exp_done, exp_idx}) begin
                n_fail++;
                $display("FAIL enable_toggle c%0d: got %b exp %b", c,
                         {data_out, busy, done, bit_idx}, {exp_out, exp_busy, exp_done, exp_idx});
            end
            if (done === 1'b1 && got == 0) got = c;
        end
        n_cmp++;
        if (got != 20) begin
            n_fail++;
            $display("FAIL enable_toggle_done_cycle: got %0d exp 20", got);
        end
        enable = 1'b1;
    endtask

    task automatic test_reload_abort();
        logic [9:0] pat;
        enable = 1'b1;
        pat    = 10'($urandom);
        start(pat, 1'b1, 16'd0);
        repeat (4) cycle();
        n_cmp++;
        if (bit_idx !== 4'd4) begin
            n_fail++;
            $display("FAIL mid_pass_idx: got %0d exp 4", bit_idx);
        end
        start(10'h3FF, 1'b1, 16'd0);
        for (int i = 0; i < 10; i++) begin
            n_cmp++;
            if (data_out !== 1'b0 || bit_idx !== 4'(i) || busy !== 1'b1) begin
                n_fail++;
                $display("FAIL reload_3ff c%0d: got out=%b idx=%0d busy=%b exp out=0 idx=%0d busy=1",
                         i, data_out, bit_idx, busy, i);
            end
            cycle();
        end
        pat  = 10'($urandom);
        stop = 1'b1;
        start(pat, 1'b0, 16'd2);
        stop = 1'b0;
        n_cmp++;
        if ({busy, done, bit_idx} !== 6'b100000 || data_out !== ~pat[0]) begin
            n_fail++;
            $display("FAIL load_stop_restart: got out=%b busy=%b done=%b idx=%0d exp out=%b busy=1 done=0 idx=0",
                     data_out, busy, done, bit_idx, ~pat[0]);
        end
        repeat (3) cycle();
        stop = 1'b1;
        cycle();
        stop = 1'b0;
        n_cmp++;
        if ({data_out, busy, done} !== 3'b100 || bit_idx !== exp_idx) begin
            n_fail++;
            $display("FAIL stop_abort: got out=%b busy=%b done=%b idx=%0d exp out=1 busy=0 done=0 idx=%0d",
                     data_out, busy, done, bit_idx, exp_idx);
        end
    endtask

    task automatic test_multi_pass();
        int got;
        got    = 0;
        enable = 1'b1;
        start(10'($urandom), 1'b1, 16'd3);
        for (int c = 1; c <= 40; c++) begin
            cycle();
            n_cmp++;
            if ({data_out, busy, done, bit_idx} !== {exp_out, exp_busy, exp_done, exp_idx}) begin
                n_fail++;
                $display("FAIL multi_pass c%0d: got %b exp %b", c,
                         {data_out, busy, done, bit_idx}, {exp_out, exp_busy, exp_done, exp_idx});
            end
            if (done === 1'b1 && got == 0) got = c;
        end
        n_cmp++;
        if (got != 30) begin
            n_fail++;
            $display("FAIL multi_pass_done_cycle: got %0d exp 30", got);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            load      = ($urandom_range(0, 24) == 0);
            stop      = ($urandom_range(0, 39) == 0);
            enable    = ($urandom_range(0, 3) != 0);
            data_in   = 10'($urandom);
            dir       = 1'($urandom);
            passes_in = 16'($urandom_range(0, 3));
            cycle();
            n_cmp++;
            if ({data_out, busy, done, bit_idx} !== {exp_out, exp_busy, exp_done, exp_idx}) begin
                n_fail++;
                $display("FAIL random c%0d: got %b exp %b", c,
                         {data_out, busy, done, bit_idx}, {exp_out, exp_busy, exp_done, exp_idx});
            end
        end
        load = 1'b0;
        stop = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_pass();
        test_continuous();
        test_enable_toggle();
        test_reload_abort();
        test_multi_pass();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
